// File: rtl/alu_multicycle.sv
// 32-bit ALU: single-cycle add/sub/xor/or/and, iterative shift-add multiply.
// Define MUL_EARLY_EXIT_EN to end a multiply once the remaining multiplier is zero.
module alu_multicycle (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [31:0] data_o,
  output logic        Zero_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [31:0] alu_res;
  logic [31:0] acc_sum;
  logic        last_iter;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (ALUCtrl_i == 3'b000): alu_res = data1_i + data2_i;
      (ALUCtrl_i == 3'b001): alu_res = data1_i - data2_i;
      (ALUCtrl_i == 3'b100): alu_res = data1_i ^ data2_i;
      (ALUCtrl_i == 3'b110): alu_res = data1_i | data2_i;
      (ALUCtrl_i == 3'b111): alu_res = data1_i & data2_i;
      default:               alu_res = '0;
    endcase
  end

  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (mplier_q[31:1] == 31'd0);
`else
  assign last_iter = (cnt_q == 5'd31);
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == 3'b010) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == 32'd0);
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        // one multiplier bit per cycle, LSB first
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (last_iter) begin
          res_d   = acc_sum;
          zero_d  = (acc_sum == 32'd0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign data_o = res_q;
  assign Zero_o = zero_q;
  assign busy_o = (state_q == MUL);
  assign done_o = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle; expected values hand-computed.
// Latency expectations follow MUL_EARLY_EXIT_EN when defined.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] data;
  logic        zero, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int n, nb;

  alu_multicycle dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (op),
    .data1_i   (a),
    .data2_i   (b),
    .data_o    (data),
    .Zero_o    (zero),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_FFFF = 17;
  localparam int BUSY_FFFF = 16;
  localparam logic BUSY_AT10 = 1'b0;
`else
  localparam int LAT_FFFF = 33;
  localparam int BUSY_FFFF = 32;
  localparam logic BUSY_AT10 = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ticks from the accepting edge to the done cycle, counting busy cycles
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    tick();
    tick();
    chk("rst_data", data, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    issue(3'b001, 32'd5, 32'd7);
    tick();
    chk("sub57_data", data, 32'hFFFF_FFFE);
    chk("sub57_zero", 32'(zero), 32'd0);
    chk("sub57_done", 32'(done), 32'd1);
    chk("sub57_busy", 32'(busy), 32'd0);
    issue(3'b001, 32'd9, 32'd9);
    tick();
    chk("sub99_data", data, 32'd0);
    chk("sub99_zero", 32'(zero), 32'd1);
    start = 1'b0;
    tick();
    chk("idle_done", 32'(done), 32'd0);

    issue(3'b010, 32'h0001_0001, 32'h0000_FFFF);
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    chk("mul_hold", data, 32'd0);
    wait_done(n, nb);
    chk("mul_lat", 32'(n), 32'(LAT_FFFF));
    chk("mul_busycnt", 32'(nb), 32'(BUSY_FFFF));
    chk("mul_data", data, 32'hFFFF_FFFF);
    chk("mul_zero", 32'(zero), 32'd0);
    chk("mul_busy_end", 32'(busy), 32'd0);

    issue(3'b010, 32'd7, 32'h0010_0000);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    issue(3'b000, 32'd1, 32'd1);
    tick();
    start = 1'b0;
    chk("drop_busy", 32'(busy), 32'd1);
    chk("drop_done", 32'(done), 32'd0);
    chk("drop_hold", data, 32'hFFFF_FFFF);
    wait_done(n, nb);
    chk("mul7_done", 32'(done), 32'd1);
    chk("mul7_data", data, 32'h0070_0000);
    issue(3'b000, 32'd1, 32'd1);
    tick();
    start = 1'b0;
    chk("b2b_add", data, 32'd2);
    chk("b2b_done", 32'(done), 32'd1);
    tick();
    chk("noreplay_done", 32'(done), 32'd0);
    chk("noreplay_data", data, 32'd2);

    issue(3'b010, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("it10_busy", 32'(busy), 32'(BUSY_AT10));
    rst = 1'b1;
    issue(3'b010, 32'd5, 32'd5);
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("abort_data", data, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("rststart_busy", 32'(busy), 32'd0);
    chk("rststart_done", 32'(done), 32'd0);
    issue(3'b010, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("mul34_done", 32'(done), 32'd1);
    chk("mul34_data", data, 32'd12);

    issue(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick();
    chk("and_data", data, 32'hF000_F000);
    chk("and_done", 32'(done), 32'd1);
    op = 3'b110;
    tick();
    chk("or_data", data, 32'hFFF0_FFF0);
    chk("or_done", 32'(done), 32'd1);
    op = 3'b100;
    tick();
    chk("xor_data", data, 32'h0FF0_0FF0);
    chk("xor_done", 32'(done), 32'd1);
    op = 3'b011;
    tick();
    chk("undef_data", data, 32'd0);
    chk("undef_zero", 32'(zero), 32'd1);
    chk("undef_done", 32'(done), 32'd1);
    issue(3'b000, 32'hFFFF_FFFF, 32'd3);
    tick();
    start = 1'b0;
    chk("add_wrap", data, 32'd2);
    chk("add_wrap_zero", 32'(zero), 32'd0);
    tick();
    chk("end_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
